// File: rtl/acia_rx.sv
// 6551-style ACIA receiver: oversampled start/data/parity/stop framing into a
// one-deep receive data register with parity, framing and overrun status.
// Latency: RX_FULL rises on the clock edge that consumes the stop-bit sample tick.
// Backpressure: none on the line; a character arriving while RX_FULL is set is
// dropped and flagged as OVERRUN.
//
// Ports:
//   CLK_14M      sole clock, rising edge
//   RESET        synchronous active-high reset
//   BAUD_EN_16X  single-cycle oversample tick (OVERSAMPLE ticks per bit)
//   RXD          asynchronous serial input, idle high
//   WORD_LEN     00=8, 01=7, 10=6, 11=5 data bits
//   PARITY_EN    parity bit present
//   PARITY_MODE  00 odd, 01 even, 10 mark, 11 space
//   RX_READ      one-cycle CPU read strobe of the receive data register
//   RX_DATA      received character, LSB aligned, unused high bits zero
//   RX_FULL      receive data register holds an unread character
//   PARITY_ERR   parity error for the character in RX_DATA
//   FRAMING_ERR  stop bit sampled low for the character in RX_DATA
//   OVERRUN      a character was lost while RX_FULL was set
module acia_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       CLK_14M,
    input  logic       RESET,
    input  logic       BAUD_EN_16X,
    input  logic       RXD,
    input  logic [1:0] WORD_LEN,
    input  logic       PARITY_EN,
    input  logic [1:0] PARITY_MODE,
    input  logic       RX_READ,
    output logic [7:0] RX_DATA,
    output logic       RX_FULL,
    output logic       PARITY_ERR,
    output logic       FRAMING_ERR,
    output logic       OVERRUN
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shreg_q;
    logic                   perr_q;
    logic [1:0]             wl_q;
    logic                   pen_q;
    logic [1:0]             pm_q;

    logic [7:0]             rx_data_q;
    logic                   rx_full_q;
    logic                   parity_err_q;
    logic                   framing_err_q;
    logic                   overrun_q;

    logic                   rxd_s;
    logic                   mid_bit;
    logic                   load_evt;
    logic [2:0]             last_idx;
    logic                   exp_par;

    assign rxd_s    = sync_q[SYNC_STAGES-1];
    // In DATA/PARITY/STOP the counter free-runs and wraps; the all-ones value
    // marks the middle of the current bit because START ended at mid-bit.
    assign mid_bit  = BAUD_EN_16X && (cnt_q == FULL_M1);
    assign load_evt = mid_bit && (state_q == S_STOP);
    assign last_idx = 3'd7 - {1'b0, wl_q};

    // Unreceived high bits of shreg_q are zero, so the XOR covers only data bits.
    always_comb begin
        exp_par = 1'b0;
        case (pm_q)
            2'b00:   exp_par = ~^shreg_q;
            2'b01:   exp_par = ^shreg_q;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            sync_q        <= '1;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            perr_q        <= 1'b0;
            wl_q          <= '0;
            pen_q         <= 1'b0;
            pm_q          <= '0;
            rx_data_q     <= '0;
            rx_full_q     <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RXD};

            // Receive data register. A read in the same cycle as a load frees
            // the register, so the new character is accepted, not lost.
            if (load_evt) begin
                if (!rx_full_q || RX_READ) begin
                    rx_data_q     <= shreg_q;
                    parity_err_q  <= perr_q;
                    framing_err_q <= ~rxd_s;
                    rx_full_q     <= 1'b1;
                    overrun_q     <= 1'b0;
                end else begin
                    overrun_q     <= 1'b1;
                end
            end else if (RX_READ) begin
                rx_full_q <= 1'b0;
                overrun_q <= 1'b0;
            end

            if (BAUD_EN_16X) begin
                case (state_q)
                    S_IDLE: begin
                        if (!rxd_s) begin
                            wl_q    <= WORD_LEN;
                            pen_q   <= PARITY_EN;
                            pm_q    <= PARITY_MODE;
                            cnt_q   <= '0;
                            state_q <= S_START;
                        end
                    end
                    S_START: begin
                        if (cnt_q == HALF_M1) begin
                            cnt_q <= '0;
                            if (!rxd_s) begin
                                bit_idx_q <= '0;
                                shreg_q   <= '0;
                                perr_q    <= 1'b0;
                                state_q   <= S_DATA;
                            end else begin
                                // Line went back high before mid-start: noise.
                                state_q <= S_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_DATA: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == FULL_M1) begin
                            shreg_q[bit_idx_q] <= rxd_s;
                            bit_idx_q          <= bit_idx_q + 1'b1;
                            if (bit_idx_q == last_idx) begin
                                state_q <= pen_q ? S_PARITY : S_STOP;
                            end
                        end
                    end
                    S_PARITY: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == FULL_M1) begin
                            perr_q  <= (rxd_s != exp_par);
                            state_q <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == FULL_M1) begin
                            // A low stop bit may be a break; wait for the line
                            // to return high before hunting for a new start.
                            state_q <= rxd_s ? S_IDLE : S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (rxd_s) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign RX_DATA     = rx_data_q;
    assign RX_FULL     = rx_full_q;
    assign PARITY_ERR  = parity_err_q;
    assign FRAMING_ERR = framing_err_q;
    assign OVERRUN     = overrun_q;

endmodule
